// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples the SPI pins in the clk domain, decodes a
// 32-bit command/address word, then either streams read data out on MISO or
// collects up to 32 write bits for the local bus sink.
module spi_slave #(
  parameter logic [7:0] READ_CMD  = 8'h03,
  parameter logic [7:0] WRITE_CMD = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic [23:0] addr,
  input  logic [31:0] rd_data,
  input  logic        rd_valid,
  output logic        wr_valid,
  output logic [31:0] wr_data,
  output logic [5:0]  wr_len,
  output logic        busy,
  output logic        underrun,
  output logic        overrun
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam logic [CNT_W-1:0] LAST_CMD_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, CMD_ADDR, RD_WAIT, DATA_RD, DATA_WR} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   cmd_word;
  logic                miso_d, cmd_valid_d, wr_valid_d, busy_d;
  logic                underrun_d, overrun_d;
  logic [7:0]          cmd_d;
  logic [23:0]         addr_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic [CNT_W-1:0]    wr_len_d;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_prev;
  logic mosi_s1, mosi_s2;
  logic [1:0] settle;
  logic sclk_rise, sclk_fall, cs_fall;

  // Pin synchronizers; cs_prev stays low until the synchronizer has flushed its
  // reset preset, so a frame already in progress at reset cannot start a decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_prev <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      settle  <= 2'b00;
    end else begin
      sclk_s1 <= spi_clk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= spi_cs_n;
      cs_s2   <= cs_s1;
      cs_prev <= settle[1] & cs_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
      settle  <= {settle[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = cs_prev & ~cs_s2;
  assign cmd_word  = {sh_q[DATA_W-2:0], mosi_s2};

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      spi_miso  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd       <= '0;
      addr      <= '0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
      wr_len    <= '0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      spi_miso  <= miso_d;
      cmd_valid <= cmd_valid_d;
      cmd       <= cmd_d;
      addr      <= addr_d;
      wr_valid  <= wr_valid_d;
      wr_data   <= wr_data_d;
      wr_len    <= wr_len_d;
      busy      <= busy_d;
      underrun  <= underrun_d;
      overrun   <= overrun_d;
    end
  end

  // Next-state and output decode; a cs_n rise pre-empts any SCLK edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    tx_d        = tx_q;
    miso_d      = spi_miso;
    cmd_valid_d = 1'b0;
    cmd_d       = cmd;
    addr_d      = addr;
    wr_valid_d  = 1'b0;
    wr_data_d   = wr_data;
    wr_len_d    = wr_len;
    underrun_d  = underrun;
    overrun_d   = overrun;

    if (state_q != IDLE && cs_s2) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      if (state_q == DATA_WR) begin
        wr_valid_d = 1'b1;
        wr_data_d  = sh_q;
        wr_len_d   = cnt_q;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            cnt_d   = '0;
            sh_d    = '0;
            state_d = CMD_ADDR;
          end
        end
        CMD_ADDR: begin
          if (sclk_rise) begin
            if (cnt_q == LAST_CMD_BIT) begin
              cmd_d       = cmd_word[31:24];
              addr_d      = cmd_word[23:0];
              cmd_valid_d = 1'b1;
              underrun_d  = 1'b0;
              overrun_d   = 1'b0;
              cnt_d       = '0;
              sh_d        = '0;
              if (cmd_word[31:24] == READ_CMD)       state_d = RD_WAIT;
              else if (cmd_word[31:24] == WRITE_CMD) state_d = DATA_WR;
              else                                   state_d = DATA_WR;
            end else begin
              sh_d  = cmd_word;
              cnt_d = CNT_W'(cnt_q + 1'b1);
            end
          end
        end
        RD_WAIT: begin
          if (rd_valid) begin
            state_d = DATA_RD;
            if (sclk_fall) begin
              miso_d = rd_data[DATA_W-1];
              tx_d   = {rd_data[DATA_W-2:0], 1'b0};
              cnt_d  = CNT_W'(1);
            end else begin
              tx_d = rd_data;
            end
          end else if (sclk_fall) begin
            underrun_d = 1'b1;
            miso_d     = 1'b0;
            tx_d       = '0;
            cnt_d      = CNT_W'(1);
            state_d    = DATA_RD;
          end
        end
        DATA_RD: begin
          if (sclk_fall) begin
            if (cnt_q < FULL_CNT) begin
              miso_d = tx_q[DATA_W-1];
              tx_d   = {tx_q[DATA_W-2:0], 1'b0};
              cnt_d  = CNT_W'(cnt_q + 1'b1);
            end else begin
              miso_d = 1'b0;
            end
          end
        end
        DATA_WR: begin
          if (sclk_rise) begin
            if (cnt_q < FULL_CNT) begin
              sh_d  = cmd_word;
              cnt_d = CNT_W'(cnt_q + 1'b1);
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE) || wr_valid_d;
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives SPI frames, predicts bus-side events
// from the frame contents and checks them as they appear.
module tb_spi_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk, spi_cs_n, spi_mosi, spi_miso;
  logic        cmd_valid, wr_valid, busy, underrun, overrun, rd_valid;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [31:0] rd_data, wr_data;
  logic [5:0]  wr_len;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_cmdq[$];
  logic [37:0] exp_wrq[$];
  logic [31:0] rd_word_g;
  bit          rd_arm = 1'b0;

  spi_slave dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cmd_valid(cmd_valid),
    .cmd(cmd), .addr(addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_len(wr_len), .busy(busy),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Bus-side event monitor against the model's expected-event queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        if (exp_cmdq.size() == 0) chk("cmd_valid_unexpected", 1, 0);
        else chk("cmd_event", {cmd, addr}, exp_cmdq.pop_front());
      end
      if (wr_valid) begin
        if (exp_wrq.size() == 0) chk("wr_valid_unexpected", 1, 0);
        else chk("wr_event", {wr_len, wr_data}, exp_wrq.pop_front());
      end
    end
  end

  // Read-data source: answers two clk after cmd_valid when armed.
  initial begin
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(negedge clk);
      if (rd_arm && cmd_valid) begin
        rd_arm = 1'b0;
        repeat (2) @(negedge clk);
        rd_data  = rd_word_g;
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
      end
    end
  end

  task automatic send_bit(input logic b, output logic rb);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b1;
    rb = spi_miso;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  // rd_mode: 0 none, 1 timely rd_valid, 2 rd_valid only after the data phase starts.
  task automatic do_frame(input logic [31:0] cw, input int ncmd, input logic [63:0] dat,
                          input int ndat, input int rd_mode, input logic [31:0] rd_word,
                          output logic [31:0] miso_word);
    int len;
    logic b;
    logic [31:0] got;
    if (ncmd == 32) begin
      exp_cmdq.push_back(cw);
      if (cw[31:24] != 8'h03) begin
        len = (ndat > 32) ? 32 : ndat;
        exp_wrq.push_back({6'(len), 32'(dat >> (64 - len))});
      end
    end
    if (rd_mode == 1) begin
      rd_word_g = rd_word;
      rd_arm    = 1'b1;
    end
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < ncmd; i++) send_bit(cw[31-i], b);
    got = '0;
    for (int i = 0; i < ndat; i++) begin
      if (rd_mode == 2 && i == 3) begin
        rd_data  = 32'hFFFF_FFFF;
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
      end
      send_bit(dat[63-i], b);
      if (i < 32) got = {got[30:0], b};
    end
    miso_word = got;
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("cmd_events_drained", 64'(exp_cmdq.size()), 0);
    chk("wr_events_drained", 64'(exp_wrq.size()), 0);
    chk("rd_source_served", 64'(rd_arm), 0);
    chk("miso_idle", 64'(spi_miso), 0);
    chk("busy_idle", 64'(busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 0);
    chk({tag, "_cmd"}, 64'(cmd), 0);
    chk({tag, "_addr"}, 64'(addr), 0);
    chk({tag, "_wr_valid"}, 64'(wr_valid), 0);
    chk({tag, "_wr_data"}, 64'(wr_data), 0);
    chk({tag, "_wr_len"}, 64'(wr_len), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_underrun"}, 64'(underrun), 0);
    chk({tag, "_overrun"}, 64'(overrun), 0);
    chk({tag, "_miso"}, 64'(spi_miso), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mw;
    logic b;
    rst = 1'b1;
    spi_clk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Full write frame.
    do_frame(32'h02AB_CDEF, 32, 64'hDEAD_BEEF_0000_0000, 32, 0, '0, mw);
    chk("wr_data_full", 64'(wr_data), 64'hDEAD_BEEF);
    chk("wr_len_full", 64'(wr_len), 32);
    chk("cmd_hold", 64'(cmd), 64'h02);
    chk("addr_hold", 64'(addr), 64'hAB_CDEF);
    chk("wr_underrun", 64'(underrun), 0);
    chk("wr_overrun", 64'(overrun), 0);

    // Timely read.
    do_frame(32'h0300_1000, 32, 64'h0, 32, 1, 32'h1234_5678, mw);
    chk("read_miso_word", 64'(mw), 64'h1234_5678);
    chk("read_underrun", 64'(underrun), 0);
    chk("read_wr_data_held", 64'(wr_data), 64'hDEAD_BEEF);

    // Late read: zeros out, underrun set.
    do_frame(32'h0300_2000, 32, 64'h0, 32, 2, '0, mw);
    chk("late_miso_word", 64'(mw), 0);
    chk("late_underrun", 64'(underrun), 1);

    // Short write; its cmd_valid clears underrun.
    do_frame(32'h0200_0040, 32, 64'hA500_0000_0000_0000, 8, 0, '0, mw);
    chk("short_wr_data", 64'(wr_data), 64'h0000_00A5);
    chk("short_wr_len", 64'(wr_len), 8);
    chk("short_underrun_cleared", 64'(underrun), 0);
    chk("short_overrun", 64'(overrun), 0);

    // Zero-length write.
    do_frame(32'h0200_0050, 32, 64'h0, 0, 0, '0, mw);
    chk("zero_wr_len", 64'(wr_len), 0);
    chk("zero_wr_data", 64'(wr_data), 0);

    // Overrun: 40 data bits, first 32 kept.
    do_frame(32'h0200_0080, 32, 64'hDEAD_BEEF_C300_0000, 40, 0, '0, mw);
    chk("ovr_wr_data", 64'(wr_data), 64'hDEAD_BEEF);
    chk("ovr_wr_len", 64'(wr_len), 32);
    chk("ovr_overrun", 64'(overrun), 1);

    // Aborted frame after 20 command bits.
    do_frame(32'h0211_1111, 20, 64'h0, 0, 0, '0, mw);
    chk("abort_addr_held", 64'(addr), 64'h00_0080);
    chk("abort_overrun_held", 64'(overrun), 1);

    // Unknown command handled as a write.
    do_frame(32'h5A12_3456, 32, 64'hA000_0000_0000_0000, 4, 0, '0, mw);
    chk("other_cmd", 64'(cmd), 64'h5A);
    chk("other_wr_data", 64'(wr_data), 64'hA);
    chk("other_overrun_cleared", 64'(overrun), 0);

    // Reset in the middle of a write data phase.
    exp_cmdq.push_back(32'h0200_0100);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] cw;
      cw = 32'h0200_0100;
      send_bit(cw[31-i], b);
    end
    for (int i = 0; i < 10; i++) send_bit(i[0], b);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, b);
    chk("midreset_ignored_busy", 64'(busy), 0);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("midreset_cmd_drained", 64'(exp_cmdq.size()), 0);
    chk("midreset_wr_data", 64'(wr_data), 0);

    // Full frame after reset release.
    do_frame(32'h02AB_CDEF, 32, 64'hCAFE_F00D_0000_0000, 32, 0, '0, mw);
    chk("post_reset_wr_data", 64'(wr_data), 64'hCAFE_F00D);
    chk("post_reset_addr", 64'(addr), 64'hAB_CDEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
